// File: rtl/keypad_operand_capture.sv
// Keypad operand capture: edge-detects decoded key presses, accumulates decimal digits
// into BCD/binary entries, and commits operand A (key A) and operand B (key #).
module keypad_operand_capture #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned BIN_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key_code,
    input  logic                    key_hold,
    output logic [BIN_W-1:0]        operand_a,
    output logic [BIN_W-1:0]        operand_b,
    output logic                    result_valid,
    output logic [4*NUM_DIGITS-1:0] disp_bcd,
    output logic [2:0]              digit_count,
    output logic                    entry_full,
    output logic [1:0]              state_o
);

    localparam int unsigned ExtW = BIN_W + 4;

    localparam logic [3:0] KeyA    = 4'd10;
    localparam logic [3:0] KeyStar = 4'd14;
    localparam logic [3:0] KeyHash = 4'd15;

    typedef enum logic [1:0] {
        StA    = 2'b00,
        StB    = 2'b01,
        StDone = 2'b10
    } state_t;

    state_t                  state;
    logic                    key_hold_d;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [BIN_W-1:0]        bin;
    logic [2:0]              count;

    logic             key_event;
    logic             is_digit;
    logic             full;
    logic [BIN_W-1:0] bin_next;

    always_comb begin
        key_event = key_hold && !key_hold_d;
        is_digit  = (key_code <= 4'd9);
        full      = (count == 3'(NUM_DIGITS));
        // Never exceeds 10^NUM_DIGITS-1, so the truncation is lossless.
        bin_next  = BIN_W'(ExtW'(bin) * ExtW'(10) + ExtW'(key_code));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StA;
            key_hold_d   <= 1'b1;  // a key held through reset must not register
            bcd          <= '0;
            bin          <= '0;
            count        <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            result_valid <= 1'b0;
        end else begin
            key_hold_d   <= key_hold;
            result_valid <= 1'b0;
            if (key_event) begin
                if (is_digit) begin
                    if (state == StDone) begin
                        operand_a <= '0;
                        operand_b <= '0;
                        bcd       <= (4*NUM_DIGITS)'(key_code);
                        bin       <= BIN_W'(key_code);
                        count     <= 3'd1;
                        state     <= StA;
                    end else if (!full) begin
                        bcd   <= {bcd[4*NUM_DIGITS-5:0], key_code};
                        bin   <= bin_next;
                        count <= count + 3'd1;
                    end
                end else begin
                    case (key_code)
                        KeyA: begin
                            if (state == StA) begin
                                operand_a <= bin;
                                bcd       <= '0;
                                bin       <= '0;
                                count     <= '0;
                                state     <= StB;
                            end
                        end
                        KeyHash: begin
                            if (state == StB) begin
                                operand_b    <= bin;
                                bcd          <= '0;
                                bin          <= '0;
                                count        <= '0;
                                result_valid <= 1'b1;
                                state        <= StDone;
                            end
                        end
                        KeyStar: begin
                            operand_a <= '0;
                            operand_b <= '0;
                            bcd       <= '0;
                            bin       <= '0;
                            count     <= '0;
                            state     <= StA;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        disp_bcd    = bcd;
        digit_count = count;
        entry_full  = full;
        state_o     = state;
    end

endmodule
